// File: rtl/dp_sequencer.sv
// Control sequencer for a register/ALU datapath: a Moore FSM (IDLE, T1..T4) that decodes bus strobes from state and latched instruction fields.
// Optional multiply/divide sequencing (opcodes 8/9, state T4) is enabled by defining DP_SEQ_MULDIV_EN.
module dp_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    input  logic [31:0] imm,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        reg_out_en,
    output logic [3:0]  reg_out_sel,
    output logic        reg_in_en,
    output logic [3:0]  reg_in_sel,
    output logic        y_in,
    output logic        z_in,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        imm_out,
    output logic        lo_in,
    output logic        hi_in,
    output logic [3:0]  alu_op
);

    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_LDI = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
`ifdef DP_SEQ_MULDIV_EN
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
`ifdef DP_SEQ_MULDIV_EN
        S_T3,
        S_T4
`else
        S_T3
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [3:0]  rc_q, rc_d;
    logic [31:0] imm_q, imm_d;
    logic        two_operand;

`ifdef DP_SEQ_MULDIV_EN
    assign two_operand = (op_q <= OP_SHR) || (op_q == OP_MUL) || (op_q == OP_DIV);
`else
    assign two_operand = (op_q <= OP_SHR);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            imm_q   <= imm_d;
        end
    end

    // Fields are captured only on the accepting edge, so later input changes cannot disturb a running op.
    always_comb begin
        op_d  = op_q;
        ra_d  = ra_q;
        rb_d  = rb_q;
        rc_d  = rc_q;
        imm_d = imm_q;
        if (state_q == S_IDLE && start) begin
            op_d  = opcode;
            ra_d  = ra;
            rb_d  = rb;
            rc_d  = rc;
            imm_d = imm;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        reg_out_en  = 1'b0;
        reg_out_sel = '0;
        reg_in_en   = 1'b0;
        reg_in_sel  = '0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        zlo_out     = 1'b0;
        zhi_out     = 1'b0;
        imm_out     = 1'b0;
        alu_op      = '0;
`ifdef DP_SEQ_MULDIV_EN
        lo_in       = 1'b0;
        hi_in       = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (start) state_d = S_T1;
            S_T1: begin
                busy = 1'b1;
                if (two_operand) begin
                    reg_out_en  = 1'b1;
                    reg_out_sel = rb_q;
                    y_in        = 1'b1;
                    state_d     = S_T2;
                end else if (op_q == OP_MOV) begin
                    reg_out_en  = 1'b1;
                    reg_out_sel = rb_q;
                    reg_in_en   = 1'b1;
                    reg_in_sel  = ra_q;
                    done        = 1'b1;
                    state_d     = S_IDLE;
                end else if (op_q == OP_LDI) begin
                    imm_out     = 1'b1;
                    reg_in_en   = 1'b1;
                    reg_in_sel  = ra_q;
                    done        = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    done        = 1'b1;
                    error       = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_T2: begin
                busy        = 1'b1;
                reg_out_en  = 1'b1;
                reg_out_sel = rc_q;
                alu_op      = op_q;
                z_in        = 1'b1;
                state_d     = S_T3;
            end
            S_T3: begin
                busy    = 1'b1;
                zlo_out = 1'b1;
`ifdef DP_SEQ_MULDIV_EN
                if (op_q == OP_MUL || op_q == OP_DIV) begin
                    lo_in   = 1'b1;
                    state_d = S_T4;
                end else begin
                    reg_in_en  = 1'b1;
                    reg_in_sel = ra_q;
                    done       = 1'b1;
                    state_d    = S_IDLE;
                end
`else
                reg_in_en  = 1'b1;
                reg_in_sel = ra_q;
                done       = 1'b1;
                state_d    = S_IDLE;
`endif
            end
`ifdef DP_SEQ_MULDIV_EN
            S_T4: begin
                busy    = 1'b1;
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifndef DP_SEQ_MULDIV_EN
    assign lo_in = 1'b0;
    assign hi_in = 1'b0;
`endif

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed self-checking bench for dp_sequencer; expectations follow DP_SEQ_MULDIV_EN when defined.
module tb_dp_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  opcode = '0, ra = '0, rb = '0, rc = '0;
    logic [31:0] imm = '0;
    logic        busy, done, error, reg_out_en, reg_in_en;
    logic [3:0]  reg_out_sel, reg_in_sel, alu_op;
    logic        y_in, z_in, zlo_out, zhi_out, imm_out, lo_in, hi_in;

    int tests  = 0;
    int failed = 0;

    dp_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc), .imm(imm),
        .busy(busy), .done(done), .error(error),
        .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
        .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel),
        .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .imm_out(imm_out), .lo_in(lo_in), .hi_in(hi_in), .alu_op(alu_op)
    );

    always #5 clock = ~clock;

    // Output snapshot: {busy,done,error,out_en,out_sel,in_en,in_sel,{y,z,zlo,zhi,imm,lo,hi},alu_op}
    function automatic logic [23:0] obs();
        return {busy, done, error, reg_out_en, reg_out_sel, reg_in_en, reg_in_sel,
                y_in, z_in, zlo_out, zhi_out, imm_out, lo_in, hi_in, alu_op};
    endfunction

    function automatic logic [23:0] mk(input logic b, input logic d, input logic e,
                                       input logic oen, input logic [3:0] osel,
                                       input logic ien, input logic [3:0] isel,
                                       input logic [6:0] strb, input logic [3:0] aop);
        return {b, d, e, oen, osel, ien, isel, strb, aop};
    endfunction

    localparam logic [6:0] ST_Y   = 7'b1000000;
    localparam logic [6:0] ST_Z   = 7'b0100000;
    localparam logic [6:0] ST_ZLO = 7'b0010000;
    localparam logic [6:0] ST_IMM = 7'b0000100;

    // Accept on a rising edge, then scramble the fields; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [31:0] im);
        @(negedge clock);
        start = 1'b1; opcode = op; ra = a; rb = b; rc = c; imm = im;
        @(posedge clock);
        #1;
        start = 1'b0; opcode = 4'hE; ra = 4'hA; rb = 4'hB; rc = 4'hC; imm = 32'hDEAD_BEEF;
    endtask

    // Compares a cycle sequence; first entry is sampled right after issue(), the rest one edge apart.
    task automatic run_seq(input string name, input logic [23:0] exp_q[$]);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                @(posedge clock);
                #1;
            end
            tests++;
            if (obs() !== exp_q[i]) begin
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs(), exp_q[i]);
                failed++;
            end
        end
    endtask

    task automatic test_reset();
        #20;
        tests++;
        if (obs() !== 24'h0) begin
            $display("FAIL reset_during: got %h expected %h", obs(), 24'h0);
            failed++;
        end
        #30 clear = 1'b0;
        @(posedge clock);
        #1;
        tests++;
        if (obs() !== 24'h0) begin
            $display("FAIL reset_after: got %h expected %h", obs(), 24'h0);
            failed++;
        end
    endtask

    task automatic test_add();
        logic [23:0] q[$];
        q = '{mk(1,0,0,1,4'd1,0,4'd0,ST_Y,4'd0),
              mk(1,0,0,1,4'd2,0,4'd0,ST_Z,4'd0),
              mk(1,1,0,0,4'd0,1,4'd3,ST_ZLO,4'd0),
              24'h0};
        issue(4'd0, 4'd3, 4'd1, 4'd2, 32'd0);
        run_seq("add", q);
    endtask

    task automatic test_shr_same_regs();
        logic [23:0] q[$];
        q = '{mk(1,0,0,1,4'd15,0,4'd0,ST_Y,4'd0),
              mk(1,0,0,1,4'd15,0,4'd0,ST_Z,4'd5),
              mk(1,1,0,0,4'd0,1,4'd15,ST_ZLO,4'd0),
              24'h0};
        issue(4'd5, 4'd15, 4'd15, 4'd15, 32'd0);
        run_seq("shr", q);
    endtask

    task automatic test_ldi();
        logic [23:0] q[$];
        q = '{mk(1,1,0,0,4'd0,1,4'd1,ST_IMM,4'd0), 24'h0};
        issue(4'd6, 4'd1, 4'd0, 4'd0, 32'd123);
        run_seq("ldi", q);
    endtask

    task automatic test_mov();
        logic [23:0] q[$];
        q = '{mk(1,1,0,1,4'd5,1,4'd5,7'b0,4'd0), 24'h0};
        issue(4'd7, 4'd5, 4'd5, 4'd9, 32'd0);
        run_seq("mov", q);
    endtask

    task automatic test_mul();
        logic [23:0] q[$];
`ifdef DP_SEQ_MULDIV_EN
        q = '{mk(1,0,0,1,4'd4,0,4'd0,ST_Y,4'd0),
              mk(1,0,0,1,4'd5,0,4'd0,ST_Z,4'd8),
              mk(1,0,0,0,4'd0,0,4'd0,7'b0010010,4'd0),
              mk(1,1,0,0,4'd0,0,4'd0,7'b0001001,4'd0),
              24'h0};
`else
        q = '{mk(1,1,1,0,4'd0,0,4'd0,7'b0,4'd0), 24'h0};
`endif
        issue(4'd8, 4'd6, 4'd4, 4'd5, 32'd0);
        run_seq("mul", q);
    endtask

    task automatic test_illegal();
        logic [23:0] q[$];
        q = '{mk(1,1,1,0,4'd0,0,4'd0,7'b0,4'd0), 24'h0};
        issue(4'd12, 4'd2, 4'd3, 4'd4, 32'd7);
        run_seq("illegal", q);
    endtask

    task automatic test_back_to_back();
        logic [23:0] e [6];
        e[0] = mk(1,0,0,1,4'd3,0,4'd0,ST_Y,4'd0);
        e[1] = mk(1,0,0,1,4'd4,0,4'd0,ST_Z,4'd1);
        e[2] = mk(1,1,0,0,4'd0,1,4'd2,ST_ZLO,4'd0);
        e[3] = 24'h0;
        e[4] = mk(1,1,1,0,4'd0,0,4'd0,7'b0,4'd0);
        e[5] = 24'h0;
        issue(4'd1, 4'd2, 4'd3, 4'd4, 32'd0);
        start = 1'b1; opcode = 4'd7; ra = 4'd9; rb = 4'd9;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(posedge clock);
                #1;
            end
            if (i == 2) opcode = 4'd15;
            if (i == 4) start = 1'b0;
            tests++;
            if (obs() !== e[i]) begin
                $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs(), e[i]);
                failed++;
            end
        end
    endtask

    task automatic test_clear_abort();
        issue(4'd0, 4'd3, 4'd1, 4'd2, 32'd0);
        @(posedge clock);
        #1;
        tests++;
        if (z_in !== 1'b1 || alu_op !== 4'd0) begin
            $display("FAIL abort_t2: got z_in=%b alu_op=%h expected z_in=1 alu_op=0", z_in, alu_op);
            failed++;
        end
        #1 clear = 1'b1;
        #1;
        tests++;
        if (obs() !== 24'h0) begin
            $display("FAIL abort_immediate: got %h expected %h", obs(), 24'h0);
            failed++;
        end
        #1 clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            tests++;
            if (obs() !== 24'h0) begin
                $display("FAIL abort_after cycle %0d: got %h expected %h", i, obs(), 24'h0);
                failed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shr_same_regs();
        test_ldi();
        test_mov();
        test_mul();
        test_illegal();
        test_back_to_back();
        test_clear_abort();
        test_add();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dp_sequencer.md
DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as follows.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 clear  in  1  async active-high reset.
REQ-004 start  in  1  operation request, sampled only in IDLE.
REQ-005 opcode  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 LDI, 7 MOV, 8 MUL, 9 DIV, 10-15 illegal.
REQ-006 ra / rb / rc  in  4 each  destination / source A / source B register index.
REQ-007 imm  in  32  immediate for LDI.
REQ-008 busy  out  1  operation in progress.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 error  out  1  qualifies done: illegal opcode.
REQ-011 reg_out_en, reg_out_sel[3:0]  out  register drives bus / which register.
REQ-012 reg_in_en, reg_in_sel[3:0]  out  register loads from bus / which register (maps to write_enableN).
REQ-013 y_in, z_in, zlo_out, zhi_out, imm_out, lo_in, hi_in  out  1 each  datapath strobes.
REQ-014 alu_op  out  4  ALU function; equals latched opcode during the ALU cycle, else 0.

Function
REQ-015 The block SHALL be a Moore FSM with states IDLE, T1, T2, T3, T4; every output is decoded from state and latched fields only.
REQ-016 In IDLE with start=1, the block SHALL latch opcode, ra, rb, rc and imm on the edge and enter T1; start in any other state SHALL be ignored.
REQ-017 busy SHALL be 1 in T1-T4, 0 in IDLE.
REQ-018 ADD-SHR: T1 reg_out_sel=rb, reg_out_en, y_in; T2 reg_out_sel=rc, reg_out_en, alu_op=opcode, z_in; T3 zlo_out, reg_in_sel=ra, reg_in_en, done; then IDLE.
REQ-019 MOV: T1 reg_out_sel=rb, reg_out_en, reg_in_sel=ra, reg_in_en, done; then IDLE.
REQ-020 LDI: T1 imm_out, reg_in_sel=ra, reg_in_en, done; then IDLE.
REQ-021 MUL/DIV (macro defined): T1, T2 as REQ-018; T3 zlo_out, lo_in; T4 zhi_out, hi_in, done; then IDLE.
REQ-022 Illegal opcode: T1 asserts done and error with all strobes 0; then IDLE.
REQ-023 Latency from accepting edge to done cycle SHALL be 1 (MOV, LDI, illegal), 3 (ALU), 4 (MUL/DIV) cycles.
REQ-024 At most one of reg_out_en, zlo_out, zhi_out, imm_out SHALL be 1 in any cycle.
REQ-025 Changes on opcode/ra/rb/rc/imm after acceptance SHALL not affect the running operation.
REQ-026 start=1 in the done cycle SHALL be ignored; a new operation is accepted at the earliest in the following IDLE cycle.
REQ-027 ra=rb or rb=rc SHALL be permitted without special handling.

Reset
REQ-028 clear=1 SHALL force IDLE immediately, regardless of clock, including mid-operation; the aborted operation produces no done.
REQ-029 During and after reset all outputs SHALL be 0, alu_op and selects 0, latched fields 0.

Configuration
REQ-030 Macro DP_SEQ_MULDIV_EN defined: opcodes 8/9 follow REQ-021 and state T4 exists.
REQ-031 Macro undefined: opcodes 8/9 SHALL be illegal (REQ-022); lo_in and hi_in SHALL be tied 0 and T4 SHALL not exist.

Verification
REQ-032 Reset: clear=1 for 50 ns, then 0 -> all outputs 0, busy=0.
REQ-033 ADD ra=3, rb=1, rc=2 -> T1 sel=1 y_in; T2 sel=2 alu_op=0 z_in; T3 zlo_out, reg_in_sel=3, done=1, error=0; busy 3 cycles.
REQ-034 LDI ra=1, imm=123 -> next cycle imm_out=1, reg_in_sel=1, reg_in_en=1, done=1.
REQ-035 MUL rb=4, rc=5: macro defined -> lo_in in T3, hi_in+done in T4; macro undefined -> done=1, error=1 in T1, no strobes.
REQ-036 start re-asserted during busy with opcode=7 -> ignored, running SUB completes with alu_op=1; opcode=15 -> done=1, error=1.
REQ-037 clear pulsed during T2 of ADD -> immediate IDLE, no done, no reg_in_en.
